// File: rtl/led18_fx_pkg.sv
// led18_fx_pkg: shared widths, mode encodings and FSM states for the LED effects driver
package led18_fx_pkg;
  localparam int LED_W = 18;
  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;
  typedef enum logic [2:0] {S_PASS, S_BLINK_ON, S_BLINK_OFF, S_ROT, S_BNC_L, S_BNC_R} state_t;
  function automatic state_t entry_state(input logic [1:0] m);
    return m == MODE_BLINK ? S_BLINK_ON : m == MODE_ROTATE ? S_ROT : m == MODE_BOUNCE ? S_BNC_L : S_PASS;
  endfunction
endpackage

// File: rtl/led18_fx_tick.sv
// led18_fx_tick: base-tick prescaler plus step counter; step fires once count reaches rate
module led18_fx_tick #(
  parameter int BASE_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic [3:0] rate,
  output logic       step
);
  localparam int PW = $clog2(BASE_DIV);
  logic [PW-1:0] pre;
  logic [3:0] cnt;
  logic base;
  assign base = pre == PW'(BASE_DIV - 1);
  // >= rather than == so that lowering rate mid-period fires at the next base tick
  assign step = base && cnt >= rate;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (clear) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= base ? '0 : pre + 1'b1;
      if (base) cnt <= step ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/led18_fx.sv
// led18_fx: static/blink/rotate/bounce effects for the 18-LED bank
// Optional PWM brightness via `LED18_FX_PWM_EN (adds the bright port).
module led18_fx
  import led18_fx_pkg::*;
#(
  parameter int BASE_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LED_W-1:0] pattern_in,
  input  logic [1:0]       mode,
  input  logic [3:0]       rate,
`ifdef LED18_FX_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [LED_W-1:0] led_out,
  output logic             step_out
);
  state_t state;
  logic [LED_W-1:0] shreg, prev_pat, fx;
  logic [1:0] prev_mode;
  logic reload, step, hold;
  assign reload = pattern_in != prev_pat || mode != prev_mode;
  assign hold = shreg[LED_W-1] & shreg[0];
  assign fx = state == S_PASS ? pattern_in : state == S_BLINK_OFF ? '0 : shreg;
  led18_fx_tick #(.BASE_DIV(BASE_DIV)) u_tick (
    .clk(clk), .reset_n(reset_n), .clear(reload), .rate(rate), .step(step)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= S_PASS;
      shreg     <= '0;
      prev_pat  <= '0;
      prev_mode <= MODE_PASS;
      step_out  <= 1'b0;
    end else begin
      prev_pat  <= pattern_in;
      prev_mode <= mode;
      step_out  <= step & ~reload;
      if (reload) begin
        shreg <= pattern_in;
        state <= entry_state(mode);
      end else if (step) begin
        case (state)
          S_BLINK_ON:  state <= S_BLINK_OFF;
          S_BLINK_OFF: state <= S_BLINK_ON;
          S_ROT:       shreg <= {shreg[LED_W-2:0], shreg[LED_W-1]};
          S_BNC_L:
            if (!hold) begin
              if (shreg[LED_W-1]) begin
                state <= S_BNC_R;
                shreg <= shreg >> 1;
              end else shreg <= shreg << 1;
            end
          S_BNC_R:
            if (!hold) begin
              if (shreg[0]) begin
                state <= S_BNC_L;
                shreg <= shreg << 1;
              end else shreg <= shreg >> 1;
            end
          default: ;
        endcase
      end
    end
`ifdef LED18_FX_PWM_EN
  logic [3:0] pwm_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pwm_cnt <= '0;
      led_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt == 4'd14 ? '0 : pwm_cnt + 1'b1;
      led_out <= fx & {LED_W{pwm_cnt < bright}};
    end
`else
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) led_out <= '0;
    else led_out <= fx;
`endif
endmodule

// File: tb/tb_led18_fx.sv
// tb_led18_fx: scoreboard bench for led18_fx with BASE_DIV=4
module tb_led18_fx;
  logic clk = 0;
  logic reset_n = 0;
  logic [17:0] pattern_in = '0;
  logic [1:0] mode = '0;
  logic [3:0] rate = '0;
  logic [17:0] led_out;
  logic step_out;
`ifdef LED18_FX_PWM_EN
  logic [3:0] bright = 4'd15;
`endif
  int cyc = 0;
  int passed = 0;
  int total = 0;
  typedef struct {string tag; bit is_step; logic [17:0] val; int at;} exp_t;
  exp_t q[$];
  exp_t cur;

  led18_fx #(.BASE_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .mode(mode), .rate(rate),
`ifdef LED18_FX_PWM_EN
    .bright(bright),
`endif
    .led_out(led_out), .step_out(step_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    else passed++;
  endtask

  task automatic push(input string tag, input bit st, input logic [17:0] v, input int at);
    q.push_back('{tag, st, v, at});
  endtask

  task automatic go(input int n);
    int d;
    d = n - cyc;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [17:0] pat, input logic [1:0] md, input logic [3:0] rt, output int p);
    pattern_in = pat;
    mode = md;
    rate = rt;
    p = cyc;
  endtask

  always @(negedge clk)
    while (q.size() > 0 && q[0].at == cyc) begin
      cur = q.pop_front();
      chk(cur.tag, cur.is_step ? {17'b0, step_out} : led_out, cur.val);
    end

  initial begin
    int p;
    #12;
    chk("reset_led", led_out, '0);
    chk("reset_step", {17'b0, step_out}, '0);
    @(posedge clk);
    #1 reset_n = 1;
    // pass-through with free-running steps
    load(18'h2A5A5, 2'd0, 4'd0, p);
    push("pass_led", 0, 18'h2A5A5, p + 1);
    push("pass_step_lo", 1, 0, p + 4);
    push("pass_step1", 1, 1, p + 5);
    push("pass_step2", 1, 1, p + 9);
    go(p + 10);
    // blink at rate 2
    load(18'h3FFFF, 2'd1, 4'd2, p);
    push("blink_on0", 0, 18'h3FFFF, p + 2);
    push("blink_step_lo", 1, 0, p + 12);
    push("blink_step1", 1, 1, p + 13);
    push("blink_on1", 0, 18'h3FFFF, p + 13);
    push("blink_step_lo2", 1, 0, p + 14);
    push("blink_off", 0, 18'h00000, p + 14);
    push("blink_step2", 1, 1, p + 25);
    push("blink_on2", 0, 18'h3FFFF, p + 26);
    go(p + 27);
    // rotate with wrap
    load(18'h20001, 2'd2, 4'd0, p);
    push("rot0", 0, 18'h20001, p + 2);
    push("rot1", 0, 18'h00003, p + 6);
    push("rot17", 0, 18'h30000, p + 70);
    push("rot18", 0, 18'h20001, p + 74);
    go(p + 75);
    // bounce with direction flips at both ends
    load(18'h10000, 2'd3, 4'd0, p);
    push("bnc0", 0, 18'h10000, p + 2);
    push("bnc1", 0, 18'h20000, p + 6);
    push("bnc2", 0, 18'h10000, p + 10);
    push("bnc3", 0, 18'h08000, p + 14);
    push("bnc18", 0, 18'h00001, p + 74);
    push("bnc19", 0, 18'h00002, p + 78);
    go(p + 79);
    // both end bits set: bounce holds
    load(18'h20001, 2'd3, 4'd0, p);
    push("hold0", 0, 18'h20001, p + 2);
    push("hold_step", 1, 1, p + 5);
    push("hold1", 0, 18'h20001, p + 6);
    push("hold5", 0, 18'h20001, p + 22);
    go(p + 23);
    // reload coincident with a step tick discards the tick
    load(18'h00001, 2'd2, 4'd1, p);
    push("prio_step1", 1, 1, p + 9);
    push("prio_led1", 0, 18'h00002, p + 10);
    go(p + 16);
    pattern_in = 18'h00100;
    push("prio_squash", 1, 0, p + 17);
    push("prio_reload", 0, 18'h00100, p + 18);
    push("prio_led_hold", 0, 18'h00100, p + 19);
    push("prio_step_lo", 1, 0, p + 24);
    push("prio_step2", 1, 1, p + 25);
    push("prio_led2", 0, 18'h00200, p + 26);
    go(p + 27);
    // zero pattern stays zero while stepping
    load(18'h00000, 2'd2, 4'd0, p);
    push("zero0", 0, 18'h00000, p + 2);
    push("zero_step", 1, 1, p + 5);
    push("zero1", 0, 18'h00000, p + 6);
    push("zero2", 0, 18'h00000, p + 10);
    go(p + 11);
    // lowering rate mid-period fires at the next base tick
    load(18'h00001, 2'd2, 4'd3, p);
    go(p + 6);
    rate = 4'd0;
    push("rate_step_lo", 1, 0, p + 8);
    push("rate_step1", 1, 1, p + 9);
    push("rate_led1", 0, 18'h00002, p + 10);
    push("rate_step2", 1, 1, p + 13);
    push("rate_led2", 0, 18'h00004, p + 14);
    go(p + 15);
    // asynchronous reset mid-rotate
    load(18'h00003, 2'd2, 4'd0, p);
    push("prerst_led", 0, 18'h00006, p + 6);
    go(p + 7);
    #2 reset_n = 0;
    #1;
    chk("rst_led", led_out, '0);
    chk("rst_step", {17'b0, step_out}, '0);
    pattern_in = '0;
    mode = '0;
    @(posedge clk);
    #1 reset_n = 1;
    load(18'h00005, 2'd0, 4'd0, p);
    push("rst_pass", 0, 18'h00005, p + 1);
    push("rst_step", 1, 1, p + 5);
    go(p + 6);
`ifdef LED18_FX_PWM_EN
    begin
      int n;
      load(18'h3FFFF, 2'd0, 4'd0, p);
      bright = 4'd5;
      go(p + 2);
      n = 0;
      repeat (15) begin @(negedge clk); n += (led_out == 18'h3FFFF); end
      chk("pwm5", 18'(n), 18'd5);
      bright = 4'd0;
      repeat (2) @(negedge clk);
      n = 0;
      repeat (15) begin @(negedge clk); n += (led_out != 18'h0); end
      chk("pwm0", 18'(n), 18'd0);
      bright = 4'd15;
      repeat (2) @(negedge clk);
      n = 0;
      repeat (15) begin @(negedge clk); n += (led_out == 18'h3FFFF); end
      chk("pwm15", 18'(n), 18'd15);
      @(posedge clk);
      #1;
    end
`endif
    go(cyc + 2);
    chk("drain", 18'(q.size()), 18'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
